// File: rtl/uart_wb_host.sv
// rtl/uart_wb_host.sv - UART command-frame initiator for the UART-to-Wishbone bridge
// Serialises read/write requests as 8N1 frames and collects read response bytes.
module uart_wb_host #(
  parameter int         DATA_WIDTH        = 32,
  parameter int         ADDR_WIDTH        = 32,
  parameter int         BAUD_RATE         = 9600,
  parameter int         CLOCK_FREQ        = 50000000,
  parameter logic [7:0] CMD_READ          = 8'h01,
  parameter logic [7:0] CMD_WRITE         = 8'hAA,
  parameter int         RESP_TIMEOUT_BITS = 40
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_we,
  input  logic [ADDR_WIDTH-1:0] i_req_adr,
  input  logic [DATA_WIDTH-1:0] i_req_dat,
  output logic                  o_rsp_valid,
  output logic [DATA_WIDTH-1:0] o_rsp_dat,
  output logic                  o_rsp_err,
  output logic                  o_uart_tx,
  input  logic                  i_uart_rx,
  output logic                  o_busy
);
  localparam int CPB  = CLOCK_FREQ / BAUD_RATE;
  localparam int TMO  = RESP_TIMEOUT_BITS * CPB;
  localparam int CW   = $clog2(CPB + 1);
  localparam int TW   = $clog2(TMO + 1);
  localparam logic [7:0]    NB_ADR   = 8'(ADDR_WIDTH / 8);
  localparam logic [7:0]    NB_DAT   = 8'(DATA_WIDTH / 8);
  localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CPB / 2 - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);

  typedef enum logic [2:0] {IDLE, SEND_CMD, SEND_ADR, SEND_DAT, RECV_DAT, DONE} state_t;

  state_t                state_q, state_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d, rd_word;
  logic [7:0]            byte_q, byte_d;
  logic [9:0]            tx_sh_q, tx_sh_d;
  logic [CW-1:0]         tx_cnt_q, tx_cnt_d;
  logic [3:0]            tx_bit_q, tx_bit_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic [DATA_WIDTH-1:0] rsp_dat_q, rsp_dat_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rx_s1_q, rx_s2_q, rx_prev_q;
  logic                  rx_act_q, rx_act_d;
  logic [CW-1:0]         rx_cnt_q, rx_cnt_d;
  logic [3:0]            rx_bit_q, rx_bit_d;
  logic [7:0]            rx_sh_q, rx_sh_d;
  logic                  rx_done, rx_ferr, tx_bit_end, tx_byte_end;

  // Receiver runs continuously; its completed bytes only matter in RECV_DAT.
  always_comb begin
    rx_act_d = rx_act_q;
    rx_cnt_d = rx_cnt_q;
    rx_bit_d = rx_bit_q;
    rx_sh_d  = rx_sh_q;
    rx_done  = 1'b0;
    rx_ferr  = 1'b0;
    if (!rx_act_q) begin
      if (rx_prev_q && !rx_s2_q) begin
        rx_act_d = 1'b1;
        rx_cnt_d = '0;
        rx_bit_d = 4'd0;
      end
    end else if (rx_bit_q == 4'd0) begin
      if (rx_cnt_q == CNT_HALF) begin
        rx_cnt_d = '0;
        if (rx_s2_q) rx_act_d = 1'b0;
        else         rx_bit_d = 4'd1;
      end else begin
        rx_cnt_d = rx_cnt_q + 1'b1;
      end
    end else if (rx_cnt_q == CNT_LAST) begin
      rx_cnt_d = '0;
      if (rx_bit_q == 4'd9) begin
        rx_act_d = 1'b0;
        rx_done  = 1'b1;
        rx_ferr  = !rx_s2_q;
      end else begin
        rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
        rx_bit_d = rx_bit_q + 4'd1;
      end
    end else begin
      rx_cnt_d = rx_cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    byte_d      = byte_q;
    tx_sh_d     = tx_sh_q;
    tx_cnt_d    = tx_cnt_q;
    tx_bit_d    = tx_bit_q;
    tmo_d       = tmo_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;
    rd_word     = (dat_q << 8) | DATA_WIDTH'(rx_sh_q);
    tx_bit_end  = (tx_cnt_q == CNT_LAST);
    tx_byte_end = tx_bit_end && (tx_bit_q == 4'd9);
    case (state_q)
      IDLE: begin
        if (i_req_valid) begin
          state_d  = SEND_CMD;
          we_d     = i_req_we;
          adr_d    = i_req_adr;
          dat_d    = i_req_dat;
          tx_sh_d  = {1'b1, (i_req_we ? CMD_WRITE : CMD_READ), 1'b0};
          tx_cnt_d = '0;
          tx_bit_d = 4'd0;
        end
      end
      SEND_CMD, SEND_ADR, SEND_DAT: begin
        if (tx_bit_end) begin
          tx_cnt_d = '0;
          tx_bit_d = tx_bit_q + 4'd1;
          tx_sh_d  = {1'b1, tx_sh_q[9:1]};
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
        // Next byte is loaded on the last stop-bit edge so bytes run back-to-back.
        if (tx_byte_end) begin
          tx_bit_d = 4'd0;
          if ((state_q == SEND_CMD) || ((state_q == SEND_ADR) && (byte_q != NB_ADR))) begin
            state_d = SEND_ADR;
            tx_sh_d = {1'b1, adr_q[ADDR_WIDTH-1 -: 8], 1'b0};
            adr_d   = adr_q << 8;
            byte_d  = (state_q == SEND_CMD) ? 8'd1 : byte_q + 8'd1;
          end else if (((state_q == SEND_ADR) && we_q) ||
                       ((state_q == SEND_DAT) && (byte_q != NB_DAT))) begin
            state_d = SEND_DAT;
            tx_sh_d = {1'b1, dat_q[DATA_WIDTH-1 -: 8], 1'b0};
            dat_d   = dat_q << 8;
            byte_d  = (state_q == SEND_ADR) ? 8'd1 : byte_q + 8'd1;
          end else if (state_q == SEND_ADR) begin
            state_d = RECV_DAT;
            tx_sh_d = '1;
            byte_d  = 8'd0;
            tmo_d   = '0;
            dat_d   = '0;
          end else begin
            state_d   = DONE;
            tx_sh_d   = '1;
            rsp_dat_d = '0;
            rsp_err_d = 1'b0;
          end
        end
      end
      RECV_DAT: begin
        if (rx_done) begin
          tmo_d = '0;
          if (rx_ferr) begin
            state_d   = DONE;
            rsp_dat_d = '0;
            rsp_err_d = 1'b1;
          end else begin
            dat_d  = rd_word;
            byte_d = byte_q + 8'd1;
            if (byte_q == NB_DAT - 8'd1) begin
              state_d   = DONE;
              rsp_dat_d = rd_word;
              rsp_err_d = 1'b0;
            end
          end
        end else if (!rx_act_q) begin
          if (tmo_q == TMO_LAST) begin
            state_d   = DONE;
            rsp_dat_d = '0;
            rsp_err_d = 1'b1;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      byte_q    <= 8'd0;
      tx_sh_q   <= '1;
      tx_cnt_q  <= '0;
      tx_bit_q  <= 4'd0;
      tmo_q     <= '0;
      rsp_dat_q <= '0;
      rsp_err_q <= 1'b0;
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
      rx_act_q  <= 1'b0;
      rx_cnt_q  <= '0;
      rx_bit_q  <= 4'd0;
      rx_sh_q   <= 8'd0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      byte_q    <= byte_d;
      tx_sh_q   <= tx_sh_d;
      tx_cnt_q  <= tx_cnt_d;
      tx_bit_q  <= tx_bit_d;
      tmo_q     <= tmo_d;
      rsp_dat_q <= rsp_dat_d;
      rsp_err_q <= rsp_err_d;
      rx_s1_q   <= i_uart_rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      rx_act_q  <= rx_act_d;
      rx_cnt_q  <= rx_cnt_d;
      rx_bit_q  <= rx_bit_d;
      rx_sh_q   <= rx_sh_d;
    end
  end

  assign o_uart_tx   = tx_sh_q[0];
  assign o_req_ready = (state_q == IDLE);
  assign o_busy      = (state_q != IDLE);
  assign o_rsp_valid = (state_q == DONE);
  assign o_rsp_dat   = rsp_dat_q;
  assign o_rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_uart_wb_host.sv
// tb/tb_uart_wb_host.sv - randomized self-checking bench for uart_wb_host
// A memory-backed bridge model answers reads; a UART monitor decodes the TX frames.
module tb_uart_wb_host;
  localparam int CPB = 10;
  localparam int LAT = 901;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_adr = '0;
  logic [31:0] req_dat = '0;
  logic        rsp_valid;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        uart_tx;
  logic        uart_rx = 1'b1;
  logic        busy;

  uart_wb_host #(.CLOCK_FREQ(1000000), .BAUD_RATE(100000)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_we(req_we),
    .i_req_adr(req_adr), .i_req_dat(req_dat),
    .o_rsp_valid(rsp_valid), .o_rsp_dat(rsp_dat), .o_rsp_err(rsp_err),
    .o_uart_tx(uart_tx), .i_uart_rx(uart_rx), .o_busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0, cyc = 0, rsp_cnt = 0;
  int t_acc, got_lat, snap;
  logic [31:0] got_dat, a, d, a2, d2;
  logic        got_err;
  logic [7:0]  tx_bytes[$], exp_q[$], mon_b;
  logic [31:0] mem[logic [31:0]];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (rsp_valid === 1'b1) rsp_cnt <= rsp_cnt + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // TX monitor: samples each bit mid-period and queues bytes with a good stop bit.
  initial forever begin
    @(negedge clk);
    if (uart_tx === 1'b0) begin
      repeat (CPB / 2 - 1) @(negedge clk);
      if (uart_tx === 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          mon_b[i] = uart_tx;
        end
        repeat (CPB) @(negedge clk);
        if (uart_tx === 1'b1) tx_bytes.push_back(mon_b);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
  endtask

  task automatic push_frame(input logic we, input logic [31:0] fa, input logic [31:0] fd);
    exp_q.push_back(we ? 8'hAA : 8'h01);
    for (int k = 3; k >= 0; k--) exp_q.push_back(8'(fa >> (8 * k)));
    if (we) for (int k = 3; k >= 0; k--) exp_q.push_back(8'(fd >> (8 * k)));
  endtask

  task automatic compare_frames(input string tag);
    int n = 0;
    while (tx_bytes.size() < exp_q.size() && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_nbytes"}, 64'(tx_bytes.size()), 64'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < tx_bytes.size(); k++)
      check($sformatf("%s_byte%0d", tag, k), 64'(tx_bytes[k]), 64'(exp_q[k]));
    tx_bytes.delete();
    exp_q.delete();
  endtask

  task automatic accept(input logic we, input logic [31:0] fa, input logic [31:0] fd);
    int n = 0;
    req_valid = 1'b1; req_we = we; req_adr = fa; req_dat = fd;
    while (req_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("accept", 64'(req_ready), 64'd1);
    t_acc = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    check("sof_low", 64'(uart_tx), 64'd0);
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (rsp_valid !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("rsp_seen", 64'(rsp_valid), 64'd1);
    got_dat = rsp_dat;
    got_err = rsp_err;
    got_lat = cyc - t_acc;
  endtask

  task automatic do_write(input logic [31:0] wa, input logic [31:0] wd);
    accept(1'b1, wa, wd);
    push_frame(1'b1, wa, wd);
    wait_rsp();
    check("wr_lat", 64'(got_lat), 64'(LAT));
    check("wr_err", 64'(got_err), 64'd0);
    check("wr_dat", 64'(got_dat), 64'd0);
    compare_frames("wr");
    mem[wa] = wd;
  endtask

  // mode 0 = normal reply, 1 = no reply (timeout), 2 = bad stop bit on second byte
  task automatic do_read(input logic [31:0] ra, input int mode);
    logic [31:0] w;
    int gap;
    w = mem.exists(ra) ? mem[ra] : $urandom();
    mem[ra] = w;
    accept(1'b0, ra, 32'h0);
    push_frame(1'b0, ra, 32'h0);
    compare_frames("rd_frame");
    if (mode == 1) begin
      wait_rsp();
      check("tmo_lat", 64'(got_lat), 64'(LAT));
      check("tmo_err", 64'(got_err), 64'd1);
      check("tmo_dat", 64'(got_dat), 64'd0);
    end else begin
      gap = $urandom_range(2, 60);
      fork
        begin
          repeat (gap) @(negedge clk);
          for (int k = 3; k >= 0; k--) begin
            send_byte(8'(w >> (8 * k)), !(mode == 2 && k == 2));
            if (mode == 2 && k == 2) break;
          end
        end
        begin
          wait_rsp();
          if (mode == 2) begin
            @(negedge clk);
            check("ferr_ready", 64'(req_ready), 64'd1);
            check("ferr_busy", 64'(busy), 64'd0);
          end
        end
      join
      if (mode == 2) begin
        check("ferr_err", 64'(got_err), 64'd1);
        check("ferr_dat", 64'(got_dat), 64'd0);
      end else begin
        check("rd_err", 64'(got_err), 64'd0);
        check("rd_dat", 64'(got_dat), 64'(w));
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_tx", 64'(uart_tx), 64'd1);
    check("rst_ready", 64'(req_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_dat", 64'(rsp_dat), 64'd0);
    check("rst_rsp_err", 64'(rsp_err), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    mem[32'h4] = 32'h12345678;
    do_write(32'h10, 32'hDEADBEEF);
    do_read(32'h4, 0);
    do_read($urandom(), 1);
    do_read($urandom(), 2);

    a = $urandom(); d = $urandom();
    accept(1'b1, a, d);
    repeat (30 * CPB + 5) @(negedge clk);
    check("rst_mid_pre_tx", 64'(uart_tx), 64'd0);
    snap = rsp_cnt;
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_tx", 64'(uart_tx), 64'd1);
    check("rst_mid_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    repeat (1000) @(negedge clk);
    check("rst_mid_no_rsp", 64'(rsp_cnt - snap), 64'd0);
    tx_bytes.delete();
    do_write($urandom(), $urandom());

    a = $urandom(); d = $urandom(); a2 = $urandom(); d2 = $urandom();
    @(negedge clk);
    snap = rsp_cnt;
    req_valid = 1'b1; req_we = 1'b1; req_adr = a; req_dat = d;
    for (int n = 0; n < 100 && req_ready !== 1'b1; n++) @(negedge clk);
    t_acc = cyc;
    @(negedge clk);
    req_adr = a2; req_dat = d2;
    push_frame(1'b1, a, d);
    push_frame(1'b1, a2, d2);
    fork
      begin
        repeat (150) @(negedge clk);
        send_byte(8'($urandom()), 1'b1);
        repeat (300) @(negedge clk);
        send_byte(8'h55, 1'b1);
      end
      begin
        wait_rsp();
        check("b2b_lat1", 64'(got_lat), 64'(LAT));
        check("b2b_err1", 64'(got_err), 64'd0);
        @(negedge clk);
        check("b2b_ready_idle", 64'(req_ready), 64'd1);
        t_acc = cyc;
        @(negedge clk);
        req_valid = 1'b0;
        check("b2b_sof", 64'(uart_tx), 64'd0);
        wait_rsp();
        check("b2b_lat2", 64'(got_lat), 64'(LAT));
        check("b2b_err2", 64'(got_err), 64'd0);
      end
    join
    compare_frames("b2b");
    @(negedge clk);
    check("b2b_rsp_count", 64'(rsp_cnt - snap), 64'd2);
    mem[a] = d;
    mem[a2] = d2;

    for (int i = 0; i < 4; i++) begin
      a = $urandom() & 32'hFFFF_FFFC;
      d = $urandom();
      do_write(a, d);
      do_read(a, 0);
      do_read($urandom(), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
